// File: rtl/secded_codec.sv
`default_nettype none
// ============================================================================
// Module   : secded_codec
// Purpose  : Pipelined Hamming SECDED encoder/decoder with a valid/ready
//            handshake on both sides and saturating error-event counters.
//            Codeword layout: bit 0 = overall parity p0, power-of-two
//            positions hold Hamming parity p1, p2, p4, ..., remaining
//            positions hold data bits in ascending order (data[0] at 3).
// Ports    : clk, reset        - clock (rising edge), async active-high reset
//            in_valid/in_ready - request handshake
//            in_mode           - 0 encode, 1 decode
//            in_data           - encode: data in low DATA_W bits; decode: codeword
//            out_valid/out_ready - result handshake
//            out_mode          - mode of the request producing the result
//            out_data          - encode: codeword; decode: data, upper bits 0
//            out_status        - 00 clean, 01 corrected, 10 uncorrectable
//            out_syndrome      - decode syndrome, 0 for encode
//            cnt_clear         - synchronous clear of both counters
//            corr_count        - consumed decode results with status 01
//            unc_count         - consumed decode results with status 10
// Revision : 1.0 - initial release
// ============================================================================
module secded_codec #(
  parameter int DATA_W = 11,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_W+PAR_W:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mode,
  output logic [DATA_W+PAR_W:0] out_data,
  output logic [1:0]            out_status,
  output logic [PAR_W-1:0]      out_syndrome,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      corr_count,
  output logic [CNT_W-1:0]      unc_count
);

  localparam int c_CW = DATA_W + PAR_W + 1;

  localparam logic [1:0] c_ST_CLEAN = 2'b00;
  localparam logic [1:0] c_ST_CORR  = 2'b01;
  localparam logic [1:0] c_ST_UNC   = 2'b10;

  // Codeword width as a PAR_W+1 bit value, for range-checking a syndrome.
  localparam logic [PAR_W:0] c_CW_L = (PAR_W + 1)'(c_CW);

  // --------------------------------------------------------------------------
  // Elaboration-time helpers
  // --------------------------------------------------------------------------
  function automatic logic is_pow2(input int i);
    return ((i & (i - 1)) == 0);
  endfunction

  // Codeword position of data bit j: the j-th non-power-of-two position >= 1.
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i < c_CW; i++) begin
      if (!is_pow2(i)) begin
        if (cnt == j) pos = i;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

  // XOR of the indices of all set bits above bit 0.
  function automatic logic [PAR_W-1:0] syndrome_of(input logic [c_CW-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int i = 1; i < c_CW; i++) begin
      if (cw[i]) s = s ^ PAR_W'(i);
    end
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic              s1_valid_q, s1_valid_d;
  logic              s1_mode_q,  s1_mode_d;
  logic [c_CW-1:0]   s1_data_q,  s1_data_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_mode_q,  s2_mode_d;
  logic [c_CW-1:0]   s2_data_q,  s2_data_d;
  logic [1:0]        s2_status_q, s2_status_d;
  logic [PAR_W-1:0]  s2_syn_q,   s2_syn_d;

  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  unc_q,  unc_d;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_in_fire;
  logic w_s2_load;
  logic w_out_fire;

  assign w_s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || w_s2_load;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = s2_valid_q && out_ready;

  // --------------------------------------------------------------------------
  // Stage 1 encode path
  // --------------------------------------------------------------------------
  // w_enc_raw holds the data bits in their codeword positions with every
  // parity position zero. Its syndrome bit k is then exactly the XOR of the
  // data positions whose index has bit k set, i.e. parity p(2^k).
  logic [c_CW-1:0]   w_enc_raw;
  logic [PAR_W-1:0]  w_enc_syn;
  logic [c_CW-1:1]   w_enc_hi;
  logic [c_CW-1:0]   w_enc_cw;

  for (genvar i = 0; i < c_CW; i++) begin : g_enc_zero
    if (is_pow2(i)) begin : g_par_slot
      assign w_enc_raw[i] = 1'b0;
    end
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_enc_place
    localparam int c_POS = data_pos(j);
    assign w_enc_raw[c_POS] = s1_data_q[j];
  end

  assign w_enc_syn = syndrome_of(w_enc_raw);

  for (genvar i = 1; i < c_CW; i++) begin : g_enc_hi
    if (is_pow2(i)) begin : g_par
      assign w_enc_hi[i] = w_enc_syn[$clog2(i)];
    end else begin : g_dat
      assign w_enc_hi[i] = w_enc_raw[i];
    end
  end

  // p0 makes the whole codeword even parity.
  assign w_enc_cw = {w_enc_hi, ^w_enc_hi};

  // --------------------------------------------------------------------------
  // Stage 1 decode path
  // --------------------------------------------------------------------------
  logic [PAR_W-1:0]  w_dec_syn;
  logic              w_dec_par;
  logic              w_syn_in_range;
  logic [c_CW-1:0]   w_dec_fix;
  logic [DATA_W-1:0] w_dec_ext;
  logic [1:0]        w_dec_status;

  assign w_dec_syn      = syndrome_of(s1_data_q);
  assign w_dec_par      = ^s1_data_q;
  assign w_syn_in_range = ({1'b0, w_dec_syn} < c_CW_L);

  // A flip happens only with odd overall parity and a syndrome naming a real
  // position; a syndrome equal to i >= 1 already implies nonzero and in range.
  assign w_dec_fix[0] = s1_data_q[0];
  for (genvar i = 1; i < c_CW; i++) begin : g_dec_fix
    assign w_dec_fix[i] = s1_data_q[i] ^ (w_dec_par && (w_dec_syn == PAR_W'(i)));
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_dec_ext
    localparam int c_POS = data_pos(j);
    assign w_dec_ext[j] = w_dec_fix[c_POS];
  end

  always_comb begin
    w_dec_status = c_ST_CLEAN;
    if (!w_dec_par) begin
      // Even parity: clean, or two flips that cancel in p0.
      if (w_dec_syn != '0) w_dec_status = c_ST_UNC;
    end else begin
      // Odd parity: single error in p0 (S=0) or at position S; a syndrome
      // pointing past the codeword cannot be a single error.
      if (w_syn_in_range) w_dec_status = c_ST_CORR;
      else                w_dec_status = c_ST_UNC;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_mode_d   = s2_mode_q;
    s2_data_d   = s2_data_q;
    s2_status_d = s2_status_q;
    s2_syn_d    = s2_syn_q;
    corr_d      = corr_q;
    unc_d       = unc_q;

    if (w_in_fire) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = in_mode;
      s1_data_d  = in_data;
    end else if (w_s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2 only loads on an advance, so out_* hold while stalled.
    if (w_s2_load) begin
      s2_valid_d = 1'b1;
      s2_mode_d  = s1_mode_q;
      if (s1_mode_q) begin
        s2_data_d   = {{(c_CW - DATA_W){1'b0}}, w_dec_ext};
        s2_status_d = w_dec_status;
        s2_syn_d    = w_dec_syn;
      end else begin
        s2_data_d   = w_enc_cw;
        s2_status_d = c_ST_CLEAN;
        s2_syn_d    = '0;
      end
    end else if (w_out_fire) begin
      s2_valid_d = 1'b0;
    end

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    if (cnt_clear) begin
      corr_d = '0;
      unc_d  = '0;
    end else if (w_out_fire && s2_mode_q) begin
      if ((s2_status_q == c_ST_CORR) && (corr_q != '1)) corr_d = corr_q + CNT_W'(1);
      if ((s2_status_q == c_ST_UNC)  && (unc_q  != '1)) unc_d  = unc_q  + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_data_q   <= '0;
      s2_status_q <= c_ST_CLEAN;
      s2_syn_q    <= '0;
      corr_q      <= '0;
      unc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_data_q   <= s2_data_d;
      s2_status_q <= s2_status_d;
      s2_syn_q    <= s2_syn_d;
      corr_q      <= corr_d;
      unc_q       <= unc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid    = s2_valid_q;
  assign out_mode     = s2_mode_q;
  assign out_data     = s2_data_q;
  assign out_status   = s2_status_q;
  assign out_syndrome = s2_syn_q;
  assign corr_count   = corr_q;
  assign unc_count    = unc_q;

endmodule
`default_nettype wire

// File: tb/tb_secded_codec.sv
`default_nettype none
// ============================================================================
// Module   : tb_secded_codec
// Purpose  : Self-checking bench for secded_codec: directed vectors, stall
//            behaviour, counter saturation/clear, reset mid-flight and
//            randomized comparison against a behavioural Hamming model at
//            four data widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secded_codec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  // ---------------- main instance (defaults) ----------------
  logic        in_valid, in_ready, in_mode;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_mode;
  logic [15:0] out_data;
  logic [1:0]  out_status;
  logic [3:0]  out_syndrome;
  logic        cnt_clear;
  logic [7:0]  corr_count, unc_count;

  secded_codec #(.DATA_W(11), .PAR_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
    .out_status(out_status), .out_syndrome(out_syndrome),
    .cnt_clear(cnt_clear), .corr_count(corr_count), .unc_count(unc_count)
  );

  // ---------------- 2-bit counter instance ----------------
  logic        c2_in_valid, c2_in_ready, c2_in_mode;
  logic [15:0] c2_in_data;
  logic        c2_out_valid, c2_out_ready, c2_out_mode;
  logic [15:0] c2_out_data;
  logic [1:0]  c2_out_status;
  logic [3:0]  c2_out_syndrome;
  logic        c2_cnt_clear;
  logic [1:0]  c2_corr, c2_unc;

  secded_codec #(.DATA_W(11), .PAR_W(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset),
    .in_valid(c2_in_valid), .in_ready(c2_in_ready), .in_mode(c2_in_mode), .in_data(c2_in_data),
    .out_valid(c2_out_valid), .out_ready(c2_out_ready), .out_mode(c2_out_mode), .out_data(c2_out_data),
    .out_status(c2_out_status), .out_syndrome(c2_out_syndrome),
    .cnt_clear(c2_cnt_clear), .corr_count(c2_corr), .unc_count(c2_unc)
  );

  // ---------------- randomized instances ----------------
  function automatic int cfg_dw(input int g);
    case (g)
      0:       return 4;
      1:       return 11;
      2:       return 26;
      default: return 57;
    endcase
  endfunction

  function automatic int cfg_pw(input int g);
    return g + 3;
  endfunction

  logic        r_valid, r_mode, r_out_ready, r_clear;
  logic [63:0] r_data [4];
  logic [3:0]  r_in_ready, r_out_valid, r_out_mode;
  logic [63:0] r_out_data [4];
  logic [7:0]  r_syn [4];
  logic [1:0]  r_status [4];
  logic [7:0]  r_corr [4];
  logic [7:0]  r_unc [4];

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int DW  = cfg_dw(g);
    localparam int PW  = cfg_pw(g);
    localparam int CWL = DW + PW + 1;
    logic [CWL-1:0] od;
    logic [PW-1:0]  sy;
    logic [1:0]     st;
    logic [7:0]     cc, uc;
    secded_codec #(.DATA_W(DW), .PAR_W(PW), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(r_valid), .in_ready(r_in_ready[g]), .in_mode(r_mode), .in_data(r_data[g][CWL-1:0]),
      .out_valid(r_out_valid[g]), .out_ready(r_out_ready), .out_mode(r_out_mode[g]), .out_data(od),
      .out_status(st), .out_syndrome(sy),
      .cnt_clear(r_clear), .corr_count(cc), .unc_count(uc)
    );
    assign r_out_data[g] = 64'(od);
    assign r_syn[g]      = 8'(sy);
    assign r_status[g]   = st;
    assign r_corr[g]     = cc;
    assign r_unc[g]      = uc;
  end

  // ---------------- behavioural reference model ----------------
  function automatic bit is_p2(input int i);
    return ((i & (i - 1)) == 0);
  endfunction

  function automatic logic [63:0] ref_encode(input logic [63:0] d, input int dw, input int pw);
    logic [63:0] cw;
    int n, j;
    logic par;
    n  = dw + pw + 1;
    cw = '0;
    j  = 0;
    for (int i = 1; i < n; i++) if (!is_p2(i)) begin cw[i] = d[j]; j++; end
    for (int k = 0; k < pw; k++) begin
      if ((1 << k) < n) begin
        par = 1'b0;
        for (int i = 1; i < n; i++)
          if (!is_p2(i) && (((i >> k) & 1) == 1)) par = par ^ cw[i];
        cw[1 << k] = par;
      end
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic void ref_decode(input logic [63:0] cw_in, input int dw, input int pw,
                                     output logic [63:0] d, output logic [1:0] st, output int s);
    logic [63:0] cw;
    int n, j, p;
    n  = dw + pw + 1;
    cw = cw_in;
    s  = 0;
    p  = 0;
    for (int i = 0; i < n; i++) if (cw[i]) begin p = p ^ 1; if (i > 0) s = s ^ i; end
    if (p == 0) st = (s == 0) ? 2'b00 : 2'b10;
    else        st = (s < n)  ? 2'b01 : 2'b10;
    if (p == 1 && s != 0 && s < n) cw[s] = ~cw[s];
    d = '0;
    j = 0;
    for (int i = 1; i < n; i++) if (!is_p2(i)) begin d[j] = cw[i]; j++; end
  endfunction

  // ---------------- single-transfer driver for main instance ----------------
  // Returns the result and the number of negedges after the accepting edge at
  // which out_valid was first seen (-1 on timeout).
  task automatic xfer(input logic m, input logic [15:0] d,
                      output logic [15:0] od, output logic [1:0] st, output logic [3:0] sy,
                      output logic om, output int lat);
    od = 'x; st = 'x; sy = 'x; om = 'x; lat = -1;
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c; od = out_data; st = out_status; sy = out_syndrome; om = out_mode;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk); #1;
    n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 16'h0)  begin n_fail++; $display("FAIL reset_out_data got %h expected 0000", out_data); end
    n_tests++; if (out_status !== 2'b0) begin n_fail++; $display("FAIL reset_status got %b expected 00", out_status); end
    n_tests++; if (out_syndrome !== 4'h0 || out_mode !== 1'b0) begin n_fail++; $display("FAIL reset_syn_mode got %h/%b expected 0/0", out_syndrome, out_mode); end
    n_tests++; if (corr_count !== 8'h0 || unc_count !== 8'h0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d expected 0/0", corr_count, unc_count); end
    n_tests++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_encode;
    logic [15:0] ins [3];
    logic [15:0] exps [3];
    logic [15:0] od; logic [1:0] st; logic [3:0] sy; logic om; int lat;
    ins[0] = 16'h0001; exps[0] = 16'h000F;
    ins[1] = 16'h0000; exps[1] = 16'h0000;
    ins[2] = 16'hF801; exps[2] = 16'h000F;  // upper bits must be ignored
    for (int t = 0; t < 3; t++) begin
      xfer(1'b0, ins[t], od, st, sy, om, lat);
      n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL enc_latency[%0d] got %0d expected 2", t, lat); end
      n_tests++; if (od !== exps[t]) begin n_fail++; $display("FAIL enc_data[%0d] got %h expected %h", t, od, exps[t]); end
      n_tests++; if (st !== 2'b00 || sy !== 4'h0 || om !== 1'b0) begin n_fail++; $display("FAIL enc_status[%0d] got st=%b syn=%h mode=%b expected 00/0/0", t, st, sy, om); end
    end
  endtask

  task automatic test_decode;
    logic [15:0] cws [4];
    logic [15:0] exd [4];
    logic [1:0]  exs [4];
    logic [3:0]  exy [4];
    int          exc [4];
    int          exu [4];
    logic [15:0] od; logic [1:0] st; logic [3:0] sy; logic om; int lat;
    cws[0] = 16'h000F; exd[0] = 16'h001; exs[0] = 2'b00; exy[0] = 4'd0; exc[0] = 0; exu[0] = 0;
    cws[1] = 16'h002F; exd[1] = 16'h001; exs[1] = 2'b01; exy[1] = 4'd5; exc[1] = 1; exu[1] = 0;
    cws[2] = 16'h000E; exd[2] = 16'h001; exs[2] = 2'b01; exy[2] = 4'd0; exc[2] = 2; exu[2] = 0;
    cws[3] = 16'h006F; exd[3] = 16'h007; exs[3] = 2'b10; exy[3] = 4'd3; exc[3] = 2; exu[3] = 1;
    for (int t = 0; t < 4; t++) begin
      xfer(1'b1, cws[t], od, st, sy, om, lat);
      n_tests++; if (od !== exd[t] || om !== 1'b1) begin n_fail++; $display("FAIL dec_data[%0d] got %h mode=%b expected %h mode=1", t, od, om, exd[t]); end
      n_tests++; if (st !== exs[t]) begin n_fail++; $display("FAIL dec_status[%0d] got %b expected %b", t, st, exs[t]); end
      n_tests++; if (sy !== exy[t]) begin n_fail++; $display("FAIL dec_syndrome[%0d] got %0d expected %0d", t, sy, exy[t]); end
      @(negedge clk);
      n_tests++; if (int'(corr_count) != exc[t] || int'(unc_count) != exu[t]) begin n_fail++; $display("FAIL dec_counts[%0d] got %0d/%0d expected %0d/%0d", t, corr_count, unc_count, exc[t], exu[t]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] vals [3];
    logic [15:0] e0, e1;
    logic [15:0] seen [$];
    int idx [$];
    int acc;
    logic fire;
    for (int i = 0; i < 3; i++) vals[i] = 11'($urandom);
    e0 = 16'(ref_encode(64'(vals[0]), 11, 4));
    e1 = 16'(ref_encode(64'(vals[1]), 11, 4));
    acc = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = 16'(vals[0]);
    for (int c = 0; c < 6; c++) begin
      #1 fire = in_ready;
      @(posedge clk); #1;
      if (fire) begin acc++; if (acc < 3) in_data = 16'(vals[acc]); end
      @(negedge clk);
    end
    #1;
    n_tests++; if (acc != 2) begin n_fail++; $display("FAIL stall_accepted got %0d expected 2", acc); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1 || out_data !== e0) begin n_fail++; $display("FAIL stall_hold got v=%b %h expected v=1 %h", out_valid, out_data, e0); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 if (out_valid) begin seen.push_back(out_data); idx.push_back(c); end
      @(negedge clk);
    end
    n_tests++; if (seen.size() != 2) begin n_fail++; $display("FAIL drain_count got %0d expected 2", seen.size()); end
    else begin
      n_tests++; if (seen[0] !== e0 || seen[1] !== e1) begin n_fail++; $display("FAIL drain_order got %h,%h expected %h,%h", seen[0], seen[1], e0, e1); end
      n_tests++; if (idx[1] - idx[0] != 1) begin n_fail++; $display("FAIL drain_rate got gap %0d expected 1", idx[1] - idx[0]); end
    end
  endtask

  task automatic test_reset_inflight;
    logic any_valid;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b1; in_data = 16'h002F;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL inflight_setup got v=%b rdy=%b expected 1/0", out_valid, in_ready); end
    reset = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 16'h0 || out_status !== 2'b00 || out_syndrome !== 4'h0 || out_mode !== 1'b0) begin n_fail++; $display("FAIL rst_async_outs got %h/%b/%h/%b expected 0", out_data, out_status, out_syndrome, out_mode); end
    n_tests++; if (corr_count !== 8'h0 || unc_count !== 8'h0) begin n_fail++; $display("FAIL rst_async_counts got %0d/%0d expected 0/0", corr_count, unc_count); end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    any_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 if (out_valid) any_valid = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (any_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale got out_valid seen expected none"); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_saturate;
    bit seen;
    @(negedge clk);
    c2_out_ready = 1'b1; c2_in_mode = 1'b1; c2_in_data = 16'h002F; c2_in_valid = 1'b1;
    repeat (5) @(negedge clk);
    c2_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (c2_corr !== 2'd3 || c2_unc !== 2'd0) begin n_fail++; $display("FAIL sat_corr got %0d/%0d expected 3/0", c2_corr, c2_unc); end
    c2_in_valid = 1'b1;
    @(negedge clk);
    c2_in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1 if (c2_out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL sat_sixth got timeout expected result"); end
    c2_cnt_clear = 1'b1;
    @(negedge clk);
    c2_cnt_clear = 1'b0;
    #1;
    n_tests++; if (c2_corr !== 2'd0) begin n_fail++; $display("FAIL sat_clear_prio got %0d expected 0", c2_corr); end
  endtask

  // Scoreboard per randomized instance (circular, depth 8).
  logic [63:0] sb_data [4][8];
  logic [1:0]  sb_st   [4][8];
  int          sb_sy   [4][8];
  logic        sb_md   [4][8];
  int          wp [4];
  int          rp [4];
  int          mc [4];
  int          mu [4];

  task automatic test_random;
    logic [63:0] nx_data [4];
    logic [1:0]  nx_st   [4];
    int          nx_sy   [4];
    logic [63:0] rnd, cw, cmask, dmask;
    int dw, pw, n, kind, a, b;
    for (int g = 0; g < 4; g++) begin wp[g] = 0; rp[g] = 0; mc[g] = 0; mu[g] = 0; end
    for (int cyc = 0; cyc < 1506; cyc++) begin
      @(negedge clk);
      if (cyc < 1500) begin
        r_valid = ($urandom % 4) != 0;
        r_out_ready = ($urandom % 4) != 0;
      end else begin
        r_valid = 1'b0;
        r_out_ready = 1'b1;
      end
      r_mode = 1'($urandom % 2);
      for (int g = 0; g < 4; g++) begin
        dw = cfg_dw(g); pw = cfg_pw(g); n = dw + pw + 1;
        cmask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        dmask = (64'd1 << dw) - 64'd1;
        rnd = {$urandom, $urandom};
        if (!r_mode) begin
          r_data[g]  = rnd & cmask;
          nx_data[g] = ref_encode(rnd & dmask, dw, pw);
          nx_st[g]   = 2'b00;
          nx_sy[g]   = 0;
        end else begin
          cw = ref_encode(rnd & dmask, dw, pw);
          kind = $urandom % 4;
          a = $urandom_range(n - 1, 0);
          b = (a + 1 + $urandom_range(n - 2, 0)) % n;
          if (kind == 1) cw[a] = ~cw[a];
          if (kind == 2) begin cw[a] = ~cw[a]; cw[b] = ~cw[b]; end
          if (kind == 3) cw = {$urandom, $urandom} & cmask;
          r_data[g] = cw;
          ref_decode(cw, dw, pw, nx_data[g], nx_st[g], nx_sy[g]);
        end
      end
      #1;
      for (int g = 0; g < 4; g++) begin
        if (r_out_valid[g] && r_out_ready) begin
          n_tests++;
          if (rp[g] == wp[g]) begin
            n_fail++; $display("FAIL rnd_unexpected[%0d] got output %h expected none", g, r_out_data[g]);
          end else begin
            if (r_out_data[g] !== sb_data[g][rp[g] % 8] || r_out_mode[g] !== sb_md[g][rp[g] % 8] ||
                r_status[g] !== sb_st[g][rp[g] % 8] || r_syn[g] !== 8'(sb_sy[g][rp[g] % 8])) begin
              n_fail++;
              $display("FAIL rnd_result[%0d] got d=%h m=%b st=%b syn=%0d expected d=%h m=%b st=%b syn=%0d", g,
                       r_out_data[g], r_out_mode[g], r_status[g], r_syn[g],
                       sb_data[g][rp[g] % 8], sb_md[g][rp[g] % 8], sb_st[g][rp[g] % 8], sb_sy[g][rp[g] % 8]);
            end
            if (sb_md[g][rp[g] % 8]) begin
              if (sb_st[g][rp[g] % 8] == 2'b01 && mc[g] < 255) mc[g]++;
              if (sb_st[g][rp[g] % 8] == 2'b10 && mu[g] < 255) mu[g]++;
            end
            rp[g]++;
          end
        end
        if (r_valid && r_in_ready[g]) begin
          sb_data[g][wp[g] % 8] = nx_data[g];
          sb_st[g][wp[g] % 8]   = nx_st[g];
          sb_sy[g][wp[g] % 8]   = nx_sy[g];
          sb_md[g][wp[g] % 8]   = r_mode;
          wp[g]++;
        end
      end
    end
    @(negedge clk); #1;
    for (int g = 0; g < 4; g++) begin
      n_tests++; if (rp[g] != wp[g]) begin n_fail++; $display("FAIL rnd_lost[%0d] got %0d results expected %0d", g, rp[g], wp[g]); end
      n_tests++; if (int'(r_corr[g]) != mc[g] || int'(r_unc[g]) != mu[g]) begin n_fail++; $display("FAIL rnd_counts[%0d] got %0d/%0d expected %0d/%0d", g, r_corr[g], r_unc[g], mc[g], mu[g]); end
    end
  endtask

  // ---------------- sequencer ----------------
  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clear = 1'b0;
    c2_in_valid = 1'b0; c2_in_mode = 1'b0; c2_in_data = '0; c2_out_ready = 1'b1; c2_cnt_clear = 1'b0;
    r_valid = 1'b0; r_mode = 1'b0; r_out_ready = 1'b1; r_clear = 1'b0;
    for (int g = 0; g < 4; g++) r_data[g] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_encode;
    test_decode;
    test_back_to_back;
    test_reset_inflight;
    test_saturate;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
